spi_master_tx: RTL and testbench

//  SPI master (mode 0, MSB first) downstream of the transmit controller. Accepts 16-bit words
//  on a dv strobe, buffers one pending word, serialises it on MOSI under cs_n, samples MISO.

---
 rtl/spi_master_tx_pkg.sv | 19 +
 rtl/spi_master_tx_clk_tick.sv | 35 +++
 rtl/spi_master_tx.sv | 189 ++++++++++++++++++
 tb/tb_spi_master_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_tx_pkg.sv
// Shared SPI definitions: FSM state encodings and default frame parameters.
package spi_master_tx_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_TRAIL = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_CLK_DIV = 2;
    localparam int unsigned DEF_CS_GAP  = 2;

    // States in which the SCLK half-period timer runs
    function automatic logic is_timed_state(input logic [2:0] st);
        return (st == ST_LEAD) || (st == ST_SHIFT) || (st == ST_TRAIL);
    endfunction

endpackage

// File: rtl/spi_master_tx_clk_tick.sv
// SCLK half-period timer: pulses tick every CLK_DIV cycles while enabled.
module spi_clk_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);
    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: cleared when idle, on restart or on wrap
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || !en || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master, MSB first, full duplex, with a one-deep pending word buffer.
module spi_master_tx
    import spi_master_tx_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned CS_GAP  = DEF_CS_GAP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              dv,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              overrun
);
    localparam int unsigned ECW = $clog2(2 * DATA_W + 1);
    localparam int unsigned GCW = $clog2(CS_GAP + 1);
    localparam logic [ECW-1:0] E_LAST_FALL = ECW'(2 * DATA_W - 2);
    localparam logic [ECW-1:0] E_END       = ECW'(2 * DATA_W - 1);
    localparam logic [GCW-1:0] G_LAST      = GCW'(CS_GAP - 1);

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_vld_q, buf_vld_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [ECW-1:0]    edge_q, edge_d;
    logic [GCW-1:0]    gap_q, gap_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic              consume;
    logic              tick;

    spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .en      (is_timed_state(state_q)),
        .restart (state_d != state_q),
        .tick    (tick)
    );

    // Frame FSM, shifters and pending-buffer next-state logic
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        edge_d     = edge_q;
        gap_d      = gap_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        overrun_d  = 1'b0;
        consume    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (buf_vld_q) begin
                    consume = 1'b1;
                    tx_sh_d = buf_q;
                    rx_sh_d = '0;
                    cs_n_d  = 1'b0;
                    mosi_d  = buf_q[DATA_W-1];
                    busy_d  = 1'b1;
                    state_d = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
                    edge_d  = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The LEAD rise is the first edge; the SHIFT ticks carry the
                // remaining 2*DATA_W-1 edges, and one extra idle tick (sclk low)
                // precedes TRAIL so cs_n spans 2*DATA_W+2 half-periods.
                if (tick) begin
                    edge_d = edge_q + ECW'(1);
                    if (edge_q == E_END) begin
                        state_d = ST_TRAIL;
                    end else if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (edge_q != E_LAST_FALL) begin
                            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                            mosi_d  = tx_sh_q[DATA_W-2];
                        end
                    end else begin
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    gap_d      = '0;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == G_LAST) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A word arriving in the same cycle the buffer drains takes its place
        if (dv && (!buf_vld_q || consume)) begin
            buf_d     = tx_data;
            buf_vld_d = 1'b1;
        end else if (consume) begin
            buf_vld_d = 1'b0;
        end
        if (dv && buf_vld_q && !consume) begin
            overrun_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            edge_q     <= '0;
            gap_q      <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            edge_q     <= edge_d;
            gap_q      <= gap_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign busy     = busy_q;
    assign ready    = !buf_vld_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: random words and slave data, timeline model of the buffer.
module tb_spi_master_tx;

    localparam int unsigned W     = 16;
    localparam int unsigned FRAME = 2 * (2 * W + 2);
    localparam int unsigned GAP   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  tx_data = '0;
    logic          dv = 1'b0;
    logic          miso;
    logic          sclk, mosi, cs_n, busy, ready, rx_valid, overrun;
    logic [W-1:0]  rx_data;

    logic [W-1:0]  tx1 = '0;
    logic          dv1 = 1'b0;
    logic          sclk1, mosi1, cs_n1, busy1, ready1, rx_valid1, overrun1;
    logic [W-1:0]  rx_data1;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard / model state
    logic [W-1:0] exp_q[$];
    int unsigned  edge_n = 0;
    int unsigned  last_cons = 0;
    int unsigned  next_free = 0;
    int           exp_ovr = 0;
    logic         loop = 1'b0;

    // monitor state
    int           cyc = 0;
    logic         in_frame = 1'b0;
    logic         prev_cs = 1'b1, prev_sclk = 1'b0;
    int           low_cnt, bits, mon_edges = 0, slave_idx = 0;
    logic [W-1:0] word, pat = '0;
    int           rise_cyc = 0, last_gap = -1, ovr_cnt = 0, idle_mosi_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    assign miso = loop ? mosi : ((in_frame && slave_idx < W) ? pat[W-1-slave_idx] : 1'b0);

    spi_master_tx #(.DATA_W(16), .CLK_DIV(2), .CS_GAP(2)) u_dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .dv(dv), .miso(miso),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .ready(ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun)
    );

    spi_master_tx #(.DATA_W(16), .CLK_DIV(1), .CS_GAP(2)) u_dut1 (
        .clk(clk), .reset(reset), .tx_data(tx1), .dv(dv1), .miso(1'b1),
        .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .busy(busy1), .ready(ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .overrun(overrun1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: acts as the SPI slave and pops the scoreboard at each frame end
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            in_frame  = 1'b0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
            mon_edges = 0;
        end else begin
            if (prev_cs && !cs_n) begin
                in_frame  = 1'b1;
                low_cnt   = 0;
                bits      = 0;
                mon_edges = 0;
                word      = '0;
                slave_idx = 0;
                pat       = W'($urandom);
                last_gap  = cyc - rise_cyc;
            end
            if (!cs_n) low_cnt++;
            if (!cs_n && sclk && !prev_sclk) begin
                word = {word[W-2:0], mosi};
                bits++;
                mon_edges++;
            end
            if (!cs_n && !sclk && prev_sclk) begin
                mon_edges++;
                slave_idx++;
            end
            if (cs_n && !prev_cs && in_frame) begin
                chk("frame_cs_low_cycles", low_cnt, FRAME);
                chk("frame_bit_count", bits, W);
                chk("frame_rx_valid", rx_valid, 1'b1);
                if (exp_q.size() == 0) begin
                    chk("frame_unexpected", 32'(word), 32'hFFFF_FFFF);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("frame_mosi_word", word, e);
                    chk("frame_rx_data", rx_data, loop ? e : pat);
                end
                in_frame = 1'b0;
                rise_cyc = cyc;
            end else if (rx_valid) begin
                chk("stray_rx_valid", rx_valid, 1'b0);
            end
            if (cs_n && mosi) idle_mosi_bad++;
            if (overrun) ovr_cnt++;
            prev_cs   = cs_n;
            prev_sclk = sclk;
        end
    end

    // Issue one dv strobe; the model decides acceptance from frame timeline arithmetic
    task automatic send(input logic [W-1:0] w);
        int unsigned j, cons;
        @(posedge clk); #1;
        j = edge_n + 1;
        tx_data = w;
        dv = 1'b1;
        if (j >= last_cons) begin
            cons = (j + 1 > next_free) ? j + 1 : next_free;
            last_cons = cons;
            next_free = cons + FRAME + GAP + 1;
            exp_q.push_back(w);
        end else begin
            exp_ovr++;
        end
        @(posedge clk); #1;
        dv = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && cs_n && !busy && ready) break;
        end
        chk("idle_timeout", 32'(i < 3000), 1);
    endtask

    initial begin
        // 1: reset
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_rx_data", rx_data, '0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_overrun", overrun, 1'b0);

        // 2: loopback frame
        loop = 1'b1;
        send(16'h0791);
        wait_idle();
        chk("loop_rx_held", rx_data, 16'h0791);
        loop = 1'b0;

        // 3: second word buffered behind a running frame
        send(16'hA5A5);
        repeat (4) @(posedge clk);
        send(16'h5A5A);
        @(negedge clk);
        chk("buffered_ready", ready, 1'b0);
        wait_idle();
        chk("b2b_cs_gap", last_gap, 3);
        chk("b2b_overrun", ovr_cnt, exp_ovr);
        chk("b2b_no_drop", exp_ovr, 0);

        // 4: third strobe dropped
        begin
            int o0;
            o0 = ovr_cnt;
            send(16'h1111);
            send(16'h2222);
            send(16'h3333);
            wait_idle();
            chk("drop_one_overrun", ovr_cnt - o0, 1);
            chk("drop_model_overrun", ovr_cnt, exp_ovr);
        end

        // 5: reset mid-frame
        send(16'hC3C3);
        for (int i = 0; i < 400 && mon_edges < 10; i++) @(negedge clk);
        chk("abort_reached_edge10", 32'(mon_edges >= 10), 1);
        reset = 1'b0;
        #1;
        chk("abort_cs_n", cs_n, 1'b1);
        chk("abort_sclk", sclk, 1'b0);
        chk("abort_rx_valid", rx_valid, 1'b0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        last_cons = 0;
        next_free = 0;
        reset = 1'b1;
        send(16'h6C3A);
        wait_idle();

        // random words, random slave data, random spacing
        for (int n = 0; n < 12; n++) begin
            send(W'($urandom));
            repeat ($urandom_range(0, 80)) @(posedge clk);
        end
        wait_idle();
        chk("rand_overrun_count", ovr_cnt, exp_ovr);
        chk("idle_mosi_zero", idle_mosi_bad, 0);

        // 6: CLK_DIV=1, miso tied high
        begin
            int low, bad_per, last_rise, done;
            logic pc, ps;
            low = 0; bad_per = 0; last_rise = -1; done = 0;
            pc = cs_n1; ps = sclk1;
            @(posedge clk); #1;
            tx1 = 16'h1234; dv1 = 1'b1;
            @(posedge clk); #1;
            dv1 = 1'b0;
            for (int i = 0; i < 300 && done == 0; i++) begin
                @(negedge clk);
                if (!cs_n1) low++;
                if (sclk1 && !ps) begin
                    if (last_rise >= 0 && i - last_rise != 2) bad_per++;
                    last_rise = i;
                end
                if (cs_n1 && !pc) begin
                    chk("div1_cs_low_cycles", low, 34);
                    chk("div1_rx_valid", rx_valid1, 1'b1);
                    chk("div1_rx_data", rx_data1, 16'hFFFF);
                    done = 1;
                end
                pc = cs_n1; ps = sclk1;
            end
            chk("div1_frame_done", done, 1);
            chk("div1_sclk_period", bad_per, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
